// File: rtl/fb_write_arbiter.sv
// fb_write_arbiter: single-port framebuffer arbiter shared by scanout reads,
// buffered SPI pixel writes and a full-screen clear sequencer.
//
// Clear sequencer states:
//   state   | meaning
//   S_IDLE  | no fill in progress; clear_start is accepted here
//   S_CLEAR | filling the active area with the latched colour, raster order
//
// Port priority each cycle: scanout read, then clear, then FIFO head.
// The FIFO is held off while a clear runs so queued pixels land on top of it.
module fb_write_arbiter #(
  parameter int X_BITS   = 10,
  parameter int Y_BITS   = 10,
  parameter int H_ACTIVE = 1024,
  parameter int V_ACTIVE = 768,
  parameter int DEPTH    = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [15:0]              wr_x,
  input  logic [15:0]              wr_y,
  input  logic [15:0]              wr_pixel,
  input  logic                     rd_req,
  input  logic [X_BITS-1:0]        rd_x,
  input  logic [Y_BITS-1:0]        rd_y,
  output logic                     rd_valid,
  output logic [15:0]              rd_data,
  input  logic                     clear_start,
  input  logic [15:0]              clear_color,
  output logic                     clear_busy,
  output logic [X_BITS+Y_BITS-1:0] mem_addr,
  output logic                     mem_we,
  output logic [15:0]              mem_wdata,
  input  logic [15:0]              mem_rdata,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              drop_count,
  output logic                     write_stall
);

  localparam int AW = $clog2(DEPTH);
  localparam int AB = X_BITS + Y_BITS;
  localparam int EW = AB + 16;

  localparam logic [15:0]       H_LIM    = 16'(H_ACTIVE);
  localparam logic [15:0]       V_LIM    = 16'(V_ACTIVE);
  localparam logic [X_BITS-1:0] CX_LAST  = X_BITS'(H_ACTIVE - 1);
  localparam logic [Y_BITS-1:0] CY_LAST  = Y_BITS'(V_ACTIVE - 1);
  localparam logic [AW:0]       FULL_LVL = (AW + 1)'(DEPTH);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_CLEAR = 1'b1;

  logic [0:0]        state;
  logic [X_BITS-1:0] cx;
  logic [Y_BITS-1:0] cy;
  logic [15:0]       color;

  logic              ready_en;
  logic [EW-1:0]     fifo_mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [EW-1:0]     head;

  logic              full;
  logic              empty;
  logic              accept;
  logic              in_range;
  logic              push;
  logic              pop;
  logic              grant_clr;
  logic              rd_p1;

  assign full        = (count == FULL_LVL);
  assign empty       = (count == '0);
  assign wr_ready    = ready_en && !full;
  assign accept      = wr_valid && wr_ready;
  assign in_range    = (wr_x < H_LIM) && (wr_y < V_LIM);
  assign push        = accept && in_range;

  assign clear_busy  = (state == S_CLEAR);
  assign grant_clr   = clear_busy && !rd_req;
  assign pop         = !empty && !rd_req && !clear_busy;
  assign write_stall = !empty && (rd_req || clear_busy);

  assign head        = fifo_mem[rd_ptr];
  assign fifo_level  = count;
  assign rd_data     = mem_rdata;

  // Hold wr_ready low while in reset so it rises on the first free cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // FIFO storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {wr_y[Y_BITS-1:0], wr_x[X_BITS-1:0], wr_pixel};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Count writes that fall outside the active area, saturating.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_count <= '0;
    end else if (accept && !in_range && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

  // Clear sequencer: walks the active area in raster order, only on granted cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= S_IDLE;
      cx    <= '0;
      cy    <= '0;
      color <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (clear_start) begin
            state <= S_CLEAR;
            cx    <= '0;
            cy    <= '0;
            color <= clear_color;
          end
        end
        S_CLEAR: begin
          if (grant_clr) begin
            if (cx == CX_LAST) begin
              cx <= '0;
              if (cy == CY_LAST) begin
                cy    <= '0;
                state <= S_IDLE;
              end else begin
                cy <= cy + Y_BITS'(1);
              end
            end else begin
              cx <= cx + X_BITS'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Registered RAM port: one owner per cycle, address held when nobody uses it.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (rd_req) begin
      mem_addr  <= {rd_y, rd_x};
      mem_we    <= 1'b0;
    end else if (grant_clr) begin
      mem_addr  <= {cy, cx};
      mem_wdata <= color;
      mem_we    <= 1'b1;
    end else if (pop) begin
      mem_addr  <= head[EW-1:16];
      mem_wdata <= head[15:0];
      mem_we    <= 1'b1;
    end else begin
      mem_we    <= 1'b0;
    end
  end

  // Read-valid pipeline: address goes out next cycle, RAM answers the one after.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_p1    <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_p1    <= rd_req;
      rd_valid <= rd_p1;
    end
  end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// tb_fb_write_arbiter: directed and random stimulus against a queue-based
// transaction model of the arbiter, with a behavioural RAM behind the port.
module tb_fb_write_arbiter;

  localparam int XB = 10;
  localparam int YB = 10;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int D  = 8;

  logic              clk;
  logic              reset_n;
  logic              wr_valid;
  logic              wr_ready;
  logic [15:0]       wr_x;
  logic [15:0]       wr_y;
  logic [15:0]       wr_pixel;
  logic              rd_req;
  logic [XB-1:0]     rd_x;
  logic [YB-1:0]     rd_y;
  logic              rd_valid;
  logic [15:0]       rd_data;
  logic              clear_start;
  logic [15:0]       clear_color;
  logic              clear_busy;
  logic [XB+YB-1:0]  mem_addr;
  logic              mem_we;
  logic [15:0]       mem_wdata;
  logic [15:0]       mem_rdata;
  logic [$clog2(D):0] fifo_level;
  logic [15:0]       drop_count;
  logic              write_stall;

  fb_write_arbiter #(
    .X_BITS(XB), .Y_BITS(YB), .H_ACTIVE(H), .V_ACTIVE(V), .DEPTH(D)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_pixel(wr_pixel),
    .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .clear_start(clear_start), .clear_color(clear_color), .clear_busy(clear_busy),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fifo_level(fifo_level), .drop_count(drop_count), .write_stall(write_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM, read-first, one cycle read latency.
  logic [15:0] ram [int];
  initial mem_rdata = 16'h0;
  always @(posedge clk) begin
    int a;
    a = int'(mem_addr);
    mem_rdata <= ram.exists(a) ? ram[a] : 16'h0;
    if (mem_we === 1'b1) ram[a] = mem_wdata;
  end

  // Reference model state.
  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t         mq[$];
  logic [15:0] rexp[$];
  logic [15:0] m_ram [int];
  bit          m_busy;
  int          m_idx;
  logic [15:0] m_color;
  int          m_drops;
  bit          m_ready_en;
  bit          m_we;
  int          m_addr;
  logic [15:0] m_wdata;
  bit          m_rv1;
  bit          m_rv;

  int n_cmp = 0;
  int n_err = 0;
  int we_seen = 0;

  function automatic logic [15:0] mlook(int a);
    return m_ram.exists(a) ? m_ram[a] : 16'h0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic model_step();
    bit busy_pre;
    bit ready_pre;
    wr_t w;
    if (!reset_n) begin
      mq.delete();
      rexp.delete();
      m_busy = 0; m_idx = 0; m_color = 0; m_drops = 0; m_ready_en = 0;
      m_we = 0; m_addr = 0; m_wdata = 0; m_rv1 = 0; m_rv = 0;
      return;
    end
    busy_pre  = m_busy;
    ready_pre = m_ready_en && (mq.size() < D);
    m_rv  = m_rv1;
    m_rv1 = rd_req;
    if (rd_req) begin
      m_we   = 0;
      m_addr = (int'(rd_y) << XB) + int'(rd_x);
      rexp.push_back(mlook(m_addr));
    end else if (busy_pre) begin
      m_we    = 1;
      m_addr  = ((m_idx / H) << XB) + (m_idx % H);
      m_wdata = m_color;
      m_ram[m_addr] = m_color;
      m_idx++;
      if (m_idx == H * V) m_busy = 0;
    end else if (mq.size() > 0) begin
      w       = mq.pop_front();
      m_we    = 1;
      m_addr  = int'(w.addr);
      m_wdata = w.data;
      m_ram[m_addr] = w.data;
    end else begin
      m_we = 0;
    end
    if (clear_start && !busy_pre) begin
      m_busy  = 1;
      m_idx   = 0;
      m_color = clear_color;
    end
    if (wr_valid && ready_pre) begin
      if (wr_x >= H || wr_y >= V) begin
        if (m_drops < 65535) m_drops++;
      end else begin
        w.addr = 32'((int'(wr_y) << XB) + int'(wr_x));
        w.data = wr_pixel;
        mq.push_back(w);
      end
    end
    m_ready_en = 1;
  endtask

  // One clock: combinational checks, edge, model update, registered checks.
  task automatic cycle();
    logic [15:0] e;
    #1;
    chk("wr_ready", 32'(wr_ready), 32'(m_ready_en && (mq.size() < D)));
    chk("write_stall", 32'(write_stall), 32'(mq.size() > 0 && (rd_req || m_busy)));
    @(posedge clk);
    model_step();
    #1;
    if (mem_we === 1'b1) we_seen++;
    chk("mem_we", 32'(mem_we), 32'(m_we));
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    if (m_we) chk("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
    chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
    chk("drop_count", 32'(drop_count), 32'(m_drops));
    chk("clear_busy", 32'(clear_busy), 32'(m_busy));
    chk("rd_valid", 32'(rd_valid), 32'(m_rv));
    if (m_rv) begin
      e = rexp.pop_front();
      chk("rd_data", 32'(rd_data), 32'(e));
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wr_valid = 0; rd_req = 0; clear_start = 0;
    rd_x = XB'($urandom); rd_y = YB'($urandom);
  endtask

  task automatic put(input int x, input int y);
    wr_valid = 1; wr_x = 16'(x); wr_y = 16'(y); wr_pixel = 16'($urandom);
  endtask

  initial begin
    int base;
    reset_n = 0; wr_valid = 0; wr_x = 0; wr_y = 0; wr_pixel = 0;
    rd_req = 0; rd_x = 0; rd_y = 0; clear_start = 0; clear_color = 0;
    @(posedge clk);
    model_step();
    @(negedge clk);
    // Reset state.
    repeat (2) cycle();
    reset_n = 1;
    idle();
    repeat (2) cycle();

    // Single write: lands two cycles after acceptance.
    put(3, 1); wr_pixel = 16'hF800; cycle();
    idle(); cycle();
    chk("single_we", 32'(mem_we), 32'(1));
    chk("single_addr", 32'(mem_addr), 32'((1 << XB) + 3));
    chk("single_data", 32'(mem_wdata), 32'hF800);
    repeat (3) cycle();
    chk("single_level", 32'(fifo_level), 32'(0));

    // Read priority: writes queue while scanout holds the port.
    base = we_seen;
    for (int i = 0; i < 20; i++) begin
      idle();
      rd_req = 1;
      if (i < 10) put($urandom_range(0, H - 1), $urandom_range(0, V - 1));
      cycle();
    end
    chk("rdprio_full", 32'(wr_ready), 32'(0));
    chk("rdprio_no_we", 32'(we_seen - base), 32'(0));
    idle();
    repeat (12) cycle();
    chk("rdprio_drained", 32'(we_seen - base), 32'(8));

    // Range drops.
    put(1024, 0); cycle();
    put(0, 768);  cycle();
    put(H, 0);    cycle();
    put(0, V);    cycle();
    put(H - 1, V - 1); cycle();
    idle(); repeat (4) cycle();
    chk("drop_total", 32'(drop_count), 32'(4));

    // Clear without reads; a second start mid-clear is ignored.
    base = we_seen;
    idle(); clear_start = 1; clear_color = 16'h07E0; cycle();
    idle(); repeat (3) cycle();
    clear_start = 1; clear_color = 16'h1234; cycle();
    idle(); repeat (10) cycle();
    chk("clear_writes", 32'(we_seen - base), 32'(H * V));

    // Clear interleaved with reads and two queued writes.
    for (int i = 0; i < 24; i++) begin
      idle();
      rd_req = (i % 2 == 1);
      clear_start = (i == 0);
      clear_color = 16'h07E0;
      if (i == 3 || i == 5) put($urandom_range(0, H - 1), $urandom_range(0, V - 1));
      cycle();
    end
    idle(); repeat (4) cycle();

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      idle();
      rd_req      = ($urandom_range(0, 2) == 0);
      clear_start = ($urandom_range(0, 39) == 0);
      clear_color = 16'($urandom);
      if ($urandom_range(0, 1) == 1) begin
        put($urandom_range(0, H + 1), $urandom_range(0, V + 1));
        if ($urandom_range(0, 15) == 0) wr_x = 16'($urandom);
      end
      cycle();
    end
    idle(); repeat (30) cycle();

    // Reset during a clear with three entries queued.
    clear_start = 1; clear_color = 16'hAAAA; cycle();
    idle();
    for (int i = 0; i < 3; i++) begin
      put(i, 1); cycle();
    end
    idle();
    chk("pre_reset_level", 32'(fifo_level), 32'(3));
    reset_n = 0; cycle();
    reset_n = 1;
    chk("post_reset_busy", 32'(clear_busy), 32'(0));
    chk("post_reset_level", 32'(fifo_level), 32'(0));
    chk("post_reset_drops", 32'(drop_count), 32'(0));
    base = we_seen;
    repeat (12) cycle();
    chk("post_reset_no_we", 32'(we_seen - base), 32'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Shares one single-port framebuffer RAM among three users:
  - the video scanout reader;
  - pixel writes from the SPI display front end, already synchronised into the clk domain;
  - a built-in clear sequencer that fills the whole active area with one colour.
- Pixel writes are buffered in a small FIFO so scanout reads always win the port without losing SPI data.
- Sits between the SPI display block's x/y/pixels/strobe outputs (via a CDC FIFO) and the framebuffer RAM used by the video timing generator.

Parameters:
- X_BITS, 10, column address bits; RAM address = {y[Y_BITS-1:0], x[X_BITS-1:0]}.
- Y_BITS, 10, row address bits.
- H_ACTIVE, 1024, visible columns; writes with x >= H_ACTIVE are dropped.
- V_ACTIVE, 768, visible rows; writes with y >= V_ACTIVE are dropped.
- DEPTH, 8, write FIFO entries; power of two, >= 2.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- wr_valid  in  1  pixel write request.
- wr_ready  out  1  FIFO can accept; equals !full.
- wr_x  in  16  pixel column.
- wr_y  in  16  pixel row.
- wr_pixel  in  16  RGB565 pixel.
- rd_req  in  1  scanout read request; highest priority, never stalled.
- rd_x  in  X_BITS  scanout column.
- rd_y  in  Y_BITS  scanout row.
- rd_valid  out  1  rd_data valid.
- rd_data  out  16  read pixel.
- clear_start  in  1  one-cycle pulse: start fill.
- clear_color  in  16  fill colour; sampled on the accepted clear_start.
- clear_busy  out  1  clear sequencer active.
- mem_addr  out  X_BITS+Y_BITS  RAM address (registered).
- mem_we  out  1  RAM write enable (registered).
- mem_wdata  out  16  RAM write data (registered).
- mem_rdata  in  16  RAM read data; valid one cycle after the address is presented.
- fifo_level  out  log2(DEPTH)+1  current FIFO occupancy.
- drop_count  out  16  out-of-range writes discarded; saturates at 16'hFFFF.
- write_stall  out  1  high in any cycle the FIFO is non-empty but not granted the port.

Behaviour:
- Reset (reset_n low at a clock edge), regardless of state or an in-progress clear:
  - FIFO emptied; state = IDLE.
  - Outputs: mem_we=0, mem_addr=0, mem_wdata=0, rd_valid=0, clear_busy=0, drop_count=0, fifo_level=0, write_stall=0.
  - wr_ready goes high on the first cycle after reset release.
- Accept rule:
  - A write is accepted when wr_valid && wr_ready.
  - If wr_x >= H_ACTIVE or wr_y >= V_ACTIVE, it is consumed but not stored, and drop_count increments (saturating).
  - Otherwise {wr_y, wr_x, wr_pixel} is pushed.
- FIFO:
  - A push in cycle N is visible to the arbiter in cycle N+1; the earliest mem_we is in N+2.
  - Push and pop in the same cycle leave the level unchanged.
  - Push is impossible when full, because wr_ready is low.
- Per-cycle port arbitration, fixed priority:
  - 1. rd_req: next cycle mem_addr={rd_y,rd_x}, mem_we=0.
  - 2. Clear sequencer if clear_busy: write clear_color at the current clear address.
  - 3. FIFO non-empty and not clear_busy: pop and write the head entry.
  - 4. Otherwise mem_we=0 and mem_addr holds its value.
- Read latency:
  - rd_req sampled in cycle N gives rd_valid=1 in cycle N+2.
  - rd_data = mem_rdata in that cycle.
  - Back-to-back rd_req gives back-to-back rd_valid.
- Clear state machine:
  - IDLE: clear_start → CLEAR; cx=0, cy=0; clear_color latched; clear_busy=1 from the next cycle.
  - CLEAR: on each granted cycle, write (cx,cy) then advance:
    - if cx==H_ACTIVE-1, then cx=0 and cy++;
    - else cx++.
  - CLEAR exit: after writing (H_ACTIVE-1, V_ACTIVE-1), return to IDLE; clear_busy drops the following cycle.
  - Cycles taken by rd_req do not advance cx/cy.
  - clear_start while clear_busy is ignored.
- Ordering:
  - The FIFO keeps accepting during a clear (until full) and drains only after the clear ends.
  - So SPI pixels queued during a clear land after it and are never overwritten by it.
- write_stall = FIFO non-empty && (rd_req || clear_busy).

Test Plan:
- Single write: wr (x=5, y=3, 0xF800) with rd_req=0 → mem_we high exactly 2 cycles after acceptance, mem_addr={10'd3,10'd5}, mem_wdata=0xF800; fifo_level returns to 0.
- Read priority: push 8 writes while rd_req is held high for 20 cycles → wr_ready low after the 8th push, no mem_we during the 20 cycles, write_stall=1, rd_valid asserted 2 cycles after each rd_req; after release, the 8 writes drain on consecutive cycles in order.
- Range drop: writes at (1024,0), (0,768), (1023,767) → first two discarded with drop_count=2; the third is written at address {10'd767,10'd1023}.
- Clear: H_ACTIVE=4, V_ACTIVE=2, clear_color=0x07E0, no reads → exactly 8 writes at (0,0),(1,0),(2,0),(3,0),(0,1),(1,1),(2,1),(3,1); clear_busy high for 8 cycles; a second clear_start mid-clear is ignored.
- Clear with interleave: the same clear with rd_req every other cycle plus 2 FIFO writes pushed mid-clear → all 8 clear writes complete with reads unchanged at latency 2; the FIFO writes appear only after clear_busy falls.
- Reset mid-operation: reset_n low for 1 cycle during a clear with FIFO level 3 → next cycle clear_busy=0, fifo_level=0, drop_count=0, mem_we=0; no further writes.
